// File: rtl/gshare_branch_predictor_if.sv
// gshare_branch_predictor_if: fetch-side lookup and EX/MEM training bundle for the gshare predictor.
interface gshare_branch_predictor_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int GHR_BITS   = 10
);
    logic                  ready;
    logic                  lk_valid;
    logic                  lk_is_branch;
    logic [ADDR_WIDTH-1:0] lk_pc;
    logic                  pred_valid;
    logic                  pred_taken;
    logic [ADDR_WIDTH-1:0] pred_target;
    logic [GHR_BITS-1:0]   pred_ghr;
    logic                  up_valid;
    logic [ADDR_WIDTH-1:0] up_pc;
    logic [GHR_BITS-1:0]   up_ghr;
    logic                  up_taken;
    logic [ADDR_WIDTH-1:0] up_target;
    logic                  up_mispredict;

    modport master (
        input  ready, pred_valid, pred_taken, pred_target, pred_ghr,
        output lk_valid, lk_is_branch, lk_pc,
        output up_valid, up_pc, up_ghr, up_taken, up_target, up_mispredict
    );

    modport slave (
        output ready, pred_valid, pred_taken, pred_target, pred_ghr,
        input  lk_valid, lk_is_branch, lk_pc,
        input  up_valid, up_pc, up_ghr, up_taken, up_target, up_mispredict
    );
endinterface

// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor: gshare direction predictor with tagged BTB, speculative GHR and mispredict repair.
module gshare_branch_predictor #(
    parameter int ADDR_WIDTH = 16,
    parameter int INDEX_BITS = 10,
    parameter int GHR_BITS   = 10,
    parameter int CTR_BITS   = 2,
    parameter int TAG_BITS   = 5
) (
    input logic                     clk,
    input logic                     rst_n,
    gshare_branch_predictor_if.slave bp
);
    localparam int DEPTH = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t                  state, state_nxt;
    logic [INDEX_BITS-1:0]   cnt;
    logic [GHR_BITS-1:0]     ghr, ghr_nxt;
    logic [CTR_BITS-1:0]     pht        [DEPTH];
    logic [TAG_BITS-1:0]     btb_tag    [DEPTH];
    logic [ADDR_WIDTH-1:0]   btb_target [DEPTH];
    logic [DEPTH-1:0]        btb_valid;
    logic                    ready, lk_fire, up_fire, lk_hit, lk_taken;
    logic [INDEX_BITS-1:0]   lk_idx, up_idx;
    logic [CTR_BITS-1:0]     up_ctr, ctr_nxt;
    logic                    unused_pc_lsb;

    function automatic logic [INDEX_BITS-1:0] idx_of(input logic [ADDR_WIDTH-1:0] pc,
                                                     input logic [GHR_BITS-1:0] g);
        return pc[INDEX_BITS:1] ^ INDEX_BITS'(g);
    endfunction

    function automatic logic [TAG_BITS-1:0] tag_of(input logic [ADDR_WIDTH-1:0] pc);
        return pc[INDEX_BITS+TAG_BITS:INDEX_BITS+1];
    endfunction

    assign unused_pc_lsb = bp.lk_pc[0] ^ bp.up_pc[0];
    assign ready    = (state == RUN);
    assign bp.ready = ready;
    assign lk_fire  = ready & bp.lk_valid;
    assign up_fire  = ready & bp.up_valid;
    assign lk_idx   = idx_of(bp.lk_pc, ghr);
    assign up_idx   = idx_of(bp.up_pc, bp.up_ghr);
    assign lk_hit   = btb_valid[lk_idx] & (btb_tag[lk_idx] == tag_of(bp.lk_pc));
    assign lk_taken = bp.lk_is_branch & pht[lk_idx][CTR_BITS-1] & lk_hit;
    assign up_ctr   = pht[up_idx];
    assign ctr_nxt  = bp.up_taken ? (&up_ctr ? up_ctr : up_ctr + 1'b1)
                                  : (|up_ctr ? up_ctr - 1'b1 : up_ctr);

    // Recovery wins over a same-cycle speculative shift; the lookup itself already used the old GHR.
    always_comb begin
        state_nxt = (state == INIT && &cnt) ? RUN : state;
        ghr_nxt   = (up_fire & bp.up_mispredict) ? {bp.up_ghr[GHR_BITS-2:0], bp.up_taken} :
                    (lk_fire & bp.lk_is_branch)  ? {ghr[GHR_BITS-2:0], lk_taken} : ghr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= INIT;
            cnt            <= '0;
            ghr            <= '0;
            bp.pred_valid  <= 1'b0;
            bp.pred_taken  <= 1'b0;
            bp.pred_target <= '0;
            bp.pred_ghr    <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= (state == INIT) ? cnt + 1'b1 : cnt;
            ghr           <= ghr_nxt;
            bp.pred_valid <= lk_fire;
            if (lk_fire) begin
                bp.pred_taken  <= lk_taken;
                bp.pred_target <= lk_hit ? btb_target[lk_idx] : '0;
                bp.pred_ghr    <= ghr;
            end
        end
    end

    // Table storage has no reset: INIT sweeps counters and valid bits before ready rises.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            pht[cnt]       <= WNT;
            btb_valid[cnt] <= 1'b0;
        end else if (up_fire) begin
            pht[up_idx] <= ctr_nxt;
            if (bp.up_taken) begin
                btb_valid[up_idx]  <= 1'b1;
                btb_tag[up_idx]    <= tag_of(bp.up_pc);
                btb_target[up_idx] <= bp.up_target;
            end
        end
    end
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// tb_gshare_branch_predictor: directed vectors with a scoreboard queue checked by a separate monitor.
module tb_gshare_branch_predictor;
    localparam int AW = 16;
    localparam int GB = 10;

    typedef struct packed {
        logic          taken;
        logic [AW-1:0] target;
        logic [GB-1:0] ghr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   n;

    always #5 clk = ~clk;

    gshare_branch_predictor_if #(.ADDR_WIDTH(AW), .GHR_BITS(GB)) bp();

    gshare_branch_predictor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bp.lk_valid = 0; bp.lk_is_branch = 0; bp.lk_pc = '0;
        bp.up_valid = 0; bp.up_pc = '0; bp.up_ghr = '0;
        bp.up_taken = 0; bp.up_target = '0; bp.up_mispredict = 0;
    endtask

    task automatic set_lk(input logic br, input logic [AW-1:0] pc);
        bp.lk_valid = 1; bp.lk_is_branch = br; bp.lk_pc = pc;
    endtask

    task automatic set_up(input logic [AW-1:0] pc, input logic [GB-1:0] g, input logic t,
                          input logic [AW-1:0] tg, input logic m);
        bp.up_valid = 1; bp.up_pc = pc; bp.up_ghr = g;
        bp.up_taken = t; bp.up_target = tg; bp.up_mispredict = m;
    endtask

    task automatic expect_pred(input logic t, input logic [AW-1:0] tg, input logic [GB-1:0] g);
        exp_t e;
        e.taken = t; e.target = tg; e.ghr = g;
        q.push_back(e);
    endtask

    task automatic lookup(input logic br, input logic [AW-1:0] pc,
                          input logic t, input logic [AW-1:0] tg, input logic [GB-1:0] g);
        set_lk(br, pc);
        expect_pred(t, tg, g);
        cyc();
        clear_inputs();
    endtask

    task automatic update(input logic [AW-1:0] pc, input logic [GB-1:0] g, input logic t,
                          input logic [AW-1:0] tg, input logic m);
        set_up(pc, g, t, tg, m);
        cyc();
        clear_inputs();
    endtask

    // Not-taken mispredict on an otherwise unused entry: pulls the GHR back to zero.
    task automatic recover();
        update(16'h0100, 10'h000, 1'b0, 16'h0000, 1'b1);
    endtask

    task automatic wait_ready(input string name);
        n = 0;
        do begin
            cyc();
            n++;
        end while (bp.ready !== 1'b1 && n < 2000);
        chk(name, n, 1024);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (bp.pred_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_pred_valid", {31'd0, bp.pred_valid}, 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    chk("pred_taken", {31'd0, bp.pred_taken}, {31'd0, mon_e.taken});
                    chk("pred_target", {16'd0, bp.pred_target}, {16'd0, mon_e.target});
                    chk("pred_ghr", {22'd0, bp.pred_ghr}, {22'd0, mon_e.ghr});
                end
            end
        end
    end

    initial begin
        clear_inputs();
        repeat (3) cyc();
        chk("rst_ready", {31'd0, bp.ready}, 0);
        chk("rst_pred_valid", {31'd0, bp.pred_valid}, 0);
        chk("rst_pred_taken", {31'd0, bp.pred_taken}, 0);
        chk("rst_pred_target", {16'd0, bp.pred_target}, 0);
        chk("rst_pred_ghr", {22'd0, bp.pred_ghr}, 0);
        rst_n = 1;
        wait_ready("init_latency");

        lookup(1, 16'h3000, 0, 16'h0000, 10'h000);
        repeat (3) update(16'h3000, 10'h000, 1, 16'h3040, 0);
        recover();
        lookup(1, 16'h3000, 1, 16'h3040, 10'h000);
        update(16'h3000, 10'h000, 1, 16'h3040, 0);
        recover();
        lookup(1, 16'h3000, 1, 16'h3040, 10'h000);

        recover();
        lookup(1, 16'h3800, 0, 16'h0000, 10'h000);

        lookup(1, 16'h3000, 1, 16'h3040, 10'h000);
        lookup(1, 16'h3002, 1, 16'h3040, 10'h001);
        lookup(0, 16'h0000, 0, 16'h0000, 10'h003);
        set_lk(1, 16'h3000);
        set_up(16'h0200, 10'h005, 0, 16'h0000, 1);
        expect_pred(0, 16'h0000, 10'h003);
        cyc();
        clear_inputs();
        lookup(0, 16'h0000, 0, 16'h0000, 10'h00A);

        recover();
        update(16'h3004, 10'h000, 1, 16'h3100, 0);
        update(16'h3004, 10'h000, 0, 16'h0000, 0);
        set_lk(1, 16'h3004);
        set_up(16'h3004, 10'h000, 1, 16'h3100, 0);
        expect_pred(0, 16'h3100, 10'h000);
        cyc();
        clear_inputs();
        lookup(1, 16'h3004, 1, 16'h3100, 10'h000);

        // Registered result is present for a moment, then the async reset wipes it.
        set_lk(1, 16'h3004);
        cyc();
        rst_n = 0;
        #1;
        chk("async_rst_ready", {31'd0, bp.ready}, 0);
        chk("async_rst_pred_valid", {31'd0, bp.pred_valid}, 0);
        chk("async_rst_pred_ghr", {22'd0, bp.pred_ghr}, 0);
        set_up(16'h0100, 10'h000, 1, 16'h1234, 1);
        cyc();
        rst_n = 1;
        repeat (500) cyc();
        chk("mid_init_ready", {31'd0, bp.ready}, 0);
        rst_n = 0;
        cyc();
        rst_n = 1;
        wait_ready("reinit_latency");
        clear_inputs();
        lookup(1, 16'h0100, 0, 16'h0000, 10'h000);

        repeat (4) cyc();
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
